// File: rtl/pio_in_debounced.sv
// ---------------------------------------------------------------------------
// pio_in_debounced
//
// Avalon-MM input port for board switches and push-buttons. Each of the
// WIDTH raw inputs is synchronised, debounced on its own, and watched for
// edges. Edges are captured in a sticky register. A maskable level interrupt
// is raised while any captured edge is also enabled.
//
// Register map (word address, all zero-extended to 32 bits):
//   0 DATA  RO    debounced input value
//   1 RAW   RO    synchroniser output (not debounced)
//   2 MASK  RW    interrupt enable per bit
//   3 EDGE  RW1C  sticky edge capture; writing 1 clears that bit
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data; bits above WIDTH are ignored
//   readdata    registered read data, valid one cycle after address
//   in_port     raw asynchronous inputs
//   irq         level interrupt, active high
// ---------------------------------------------------------------------------
module pio_in_debounced #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [CNT_W-1:0] r_cnt  [WIDTH];
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge_cap;

    logic [WIDTH-1:0] w_sync_out;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_wr       = chipselect & ~write_n;
    assign w_clr      = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Upper write-data bits are deliberately ignored for narrow ports.
    assign w_unused_wdata = ^writedata;

    // Synchroniser chain. These are individual flops, not a RAM, so every
    // stage is reset to keep the post-reset RAW value defined.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge value of its neighbours, giving a true shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    // Per-bit debounce: a bit is accepted only after it has differed from
    // the accepted value for DEBOUNCE_CYCLES consecutive cycles. Any return
    // to the accepted value restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
        end else begin
            r_stable_d <= r_stable;
            for (int i = 0; i < WIDTH; i++) begin
                if (w_sync_out[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= w_sync_out[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Edge selection on the debounced value.
    always_comb begin
        // NOTE: default first so no path through this block infers a latch.
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = r_stable & ~r_stable_d;
            1:       w_edge = ~r_stable & r_stable_d;
            default: w_edge = r_stable ^ r_stable_d;
        endcase
    end

    // Mask and sticky capture. OR-ing the new edge after the clear makes a
    // same-cycle set win over a software clear, so no edge is ever lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask     <= '0;
            r_edge_cap <= '0;
        end else begin
            if (w_wr && address == 2'd2) r_mask <= writedata[WIDTH-1:0];
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0:    w_rd_mux[WIDTH-1:0] = r_stable;
            2'd1:    w_rd_mux[WIDTH-1:0] = w_sync_out;
            2'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
            default: w_rd_mux[WIDTH-1:0] = r_edge_cap;
        endcase
    end

    // Registered every cycle: readdata shows state from before this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= w_rd_mux;
    end

    // Driven only by flops, so the interrupt line cannot glitch.
    assign irq = |(r_edge_cap & r_mask);

endmodule

// File: tb/tb_pio_in_debounced.sv
// ---------------------------------------------------------------------------
// tb_pio_in_debounced
//
// Self-checking bench for pio_in_debounced. Two instances share the bus:
// u_dut8  WIDTH=8,  EDGE_TYPE=0 (rising),  SYNC_STAGES=2, DEBOUNCE_CYCLES=4
// u_dut32 WIDTH=32, EDGE_TYPE=1 (falling), SYNC_STAGES=2, DEBOUNCE_CYCLES=4
// Register-level checks on the 8-bit port run from a vector table; latency,
// glitch, collision and wide-port cases are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_pio_in_debounced;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd8;
    logic [31:0] rd32;
    logic [7:0]  in8;
    logic [31:0] in32;
    logic        irq8;
    logic        irq32;

    int checks = 0;
    int errors = 0;

    pio_in_debounced #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)
    ) u_dut8 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(rd8), .in_port(in8), .irq(irq8)
    );

    pio_in_debounced #(
        .WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)
    ) u_dut32 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(rd32), .in_port(in32), .irq(irq32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        bit          exp_irq;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit wr, logic [1:0] addr, logic [31:0] data,
                                logic [31:0] exp_rd, bit exp_irq, string name);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data;
        v.exp_rd = exp_rd; v.exp_irq = exp_irq; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Samples #1 after the rising edge, away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_read(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in8        = '0;
        in32       = '0;

        // ---------------- reset ----------------
        #23;
        check("reset_irq", {31'b0, irq8}, 32'h0);
        check("reset_readdata", rd8, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Reset-state register reads.
        vecs.delete();
        vecs.push_back(mk(0, 2'd0, 0, 32'h0000_0000, 0, "rst_data"));
        vecs.push_back(mk(0, 2'd1, 0, 32'h0000_0000, 0, "rst_raw"));
        vecs.push_back(mk(0, 2'd2, 0, 32'h0000_0000, 0, "rst_mask"));
        vecs.push_back(mk(0, 2'd3, 0, 32'h0000_0000, 0, "rst_edge"));
        foreach (vecs[i]) begin
            bus_read(vecs[i].addr);
            check({vecs[i].name, "_rd"}, rd8, vecs[i].exp_rd);
            check({vecs[i].name, "_irq"}, {31'b0, irq8}, {31'b0, vecs[i].exp_irq});
        end

        // ---------------- glitch reject ----------------
        // Two 3-cycle pulses with a 1-cycle gap: each is one cycle short of
        // acceptance, and the gap must restart the count.
        in8 = 8'h01; ticks(3);
        in8 = 8'h00; ticks(1);
        in8 = 8'h01; ticks(3);
        in8 = 8'h00; ticks(8);
        bus_read(2'd0);
        check("glitch_data", rd8, 32'h0);
        bus_read(2'd3);
        check("glitch_edge", rd8, 32'h0);

        // ---------------- debounce accept latency ----------------
        // in_port changes before edge 1. readdata after edge k shows the
        // register state after edge k-1.
        in8 = 8'h05; address = 2'd1; chipselect = 1'b1;
        tick();                                    // edge 1
        tick();                                    // edge 2
        check("raw_before_e2", rd8, 32'h0);        // RAW after e1
        tick();                                    // edge 3
        check("raw_after_e2", rd8, 32'h05);        // RAW after e2
        address = 2'd0;
        ticks(2);                                  // edges 4,5
        tick();                                    // edge 6
        check("data_before_e6", rd8, 32'h0);       // DATA after e5
        tick();                                    // edge 7
        check("data_after_e6", rd8, 32'h05);       // DATA after e6
        address = 2'd3;
        tick();                                    // edge 8
        check("edge_after_e7", rd8, 32'h05);       // EDGE after e7
        check("irq_masked", {31'b0, irq8}, 32'h0);
        chipselect = 1'b0;

        // ---------------- interrupt / clear / write rules ----------------
        vecs.delete();
        vecs.push_back(mk(1, 2'd2, 32'h0000_0001, 0, 1, "wr_mask1"));
        vecs.push_back(mk(0, 2'd2, 0, 32'h0000_0001, 1, "rd_mask1"));
        vecs.push_back(mk(1, 2'd3, 32'h0000_0001, 0, 0, "clr_edge1"));
        vecs.push_back(mk(0, 2'd3, 0, 32'h0000_0004, 0, "rd_edge4"));
        vecs.push_back(mk(1, 2'd3, 32'h0000_0004, 0, 0, "clr_edge4"));
        vecs.push_back(mk(0, 2'd3, 0, 32'h0000_0000, 0, "rd_edge0"));
        vecs.push_back(mk(1, 2'd0, 32'h0000_00FF, 0, 0, "wr_data_ign"));
        vecs.push_back(mk(0, 2'd0, 0, 32'h0000_0005, 0, "rd_data5"));
        vecs.push_back(mk(1, 2'd1, 32'h0000_00FF, 0, 0, "wr_raw_ign"));
        vecs.push_back(mk(0, 2'd1, 0, 32'h0000_0005, 0, "rd_raw5"));
        vecs.push_back(mk(1, 2'd2, 32'hABCD_EF05, 0, 0, "wr_mask_wide"));
        vecs.push_back(mk(0, 2'd2, 0, 32'h0000_0005, 0, "rd_mask_trunc"));
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr);
                check({vecs[i].name, "_rd"}, rd8, vecs[i].exp_rd);
            end
            check({vecs[i].name, "_irq"}, {31'b0, irq8}, {31'b0, vecs[i].exp_irq});
        end

        // ---------------- set-wins collision ----------------
        // Bit 1 rises at edge 6 after the change, is captured at edge 7;
        // the clear of bit 1 is written at that same edge 7.
        in8 = 8'h07;
        ticks(6);
        bus_write(2'd3, 32'h0000_0002);            // edge 7
        bus_read(2'd3);
        check("collide_edge", rd8, 32'h0000_0002);
        check("collide_irq_masked", {31'b0, irq8}, 32'h0);
        bus_write(2'd2, 32'h0000_0002);
        check("collide_irq_on", {31'b0, irq8}, 32'h1);
        bus_write(2'd3, 32'h0000_0002);
        check("collide_clr_irq", {31'b0, irq8}, 32'h0);
        bus_read(2'd3);
        check("collide_clr_edge", rd8, 32'h0);

        // ---------------- 32-bit, falling-edge instance ----------------
        in32 = 32'hFFFF_FFFF;
        ticks(10);
        bus_read(2'd0);
        check("w32_data_ones", rd32, 32'hFFFF_FFFF);
        bus_read(2'd3);
        check("w32_no_rise_edge", rd32, 32'h0);
        in32 = 32'h0000_FFFF;
        ticks(10);
        bus_read(2'd3);
        check("w32_fall_edge", rd32, 32'hFFFF_0000);
        check("w32_irq_masked", {31'b0, irq32}, 32'h0);
        bus_write(2'd2, 32'h0001_0000);
        check("w32_irq_on", {31'b0, irq32}, 32'h1);
        bus_write(2'd3, 32'h8001_0000);
        check("w32_irq_off", {31'b0, irq32}, 32'h0);
        bus_read(2'd3);
        check("w32_edge_clr", rd32, 32'h7FFE_0000);
        bus_read(2'd1);
        check("w32_raw", rd32, 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
